// File: rtl/dcache_writeback_buffer_pkg.sv
// Shared types for the dmem write-back buffer: entry layout, FSM state encodings
// and the fixed line-offset width of a physical line address.
package wbuf_types;

    localparam int WBUF_ADDR_W   = 32;
    localparam int WBUF_LINE_W   = 256;
    localparam int LINE_OFFSET_W = 5;
    localparam int WBUF_TAG_W    = WBUF_ADDR_W - LINE_OFFSET_W;

    // One buffer slot at the default geometry; tag is addr[ADDR_W-1:5].
    typedef struct packed {
        logic                   valid;
        logic [WBUF_TAG_W-1:0]  tag;
        logic [WBUF_LINE_W-1:0] line;
    } wbuf_entry_t;

    typedef enum logic {
        U_IDLE,
        U_RESP
    } ustate_t;

    typedef enum logic [1:0] {
        D_IDLE,
        D_READ,
        D_WRITE
    } dstate_t;

endpackage

// File: rtl/dcache_writeback_buffer_match.sv
// Combinational tag CAM over the buffer slots. Scans from the head (oldest) so the
// youngest matching slot wins; optionally ignores the head while it is being drained.
module wbuf_match #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 27,
    parameter int LINE_W = 256,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]             valid,
    input  logic [DEPTH-1:0][TAG_W-1:0]  tags,
    input  logic [DEPTH-1:0][LINE_W-1:0] lines,
    input  logic [PTR_W-1:0]             head,
    input  logic [TAG_W-1:0]             lookup_tag,
    input  logic                         exclude_head,
    output logic                         hit,
    output logic [PTR_W-1:0]             index,
    output logic [LINE_W-1:0]            line
);

    logic [PTR_W-1:0] slot;

    // NOTE: every variable written here gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        slot  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = head + PTR_W'(i);
            if (valid[slot] && (tags[slot] == lookup_tag) && !(exclude_head && (i == 0))) begin
                hit   = 1'b1;
                index = slot;
            end
        end
    end

    assign line = lines[index];

endmodule

// File: rtl/dcache_writeback_buffer.sv
// Victim/write-back buffer between the dmem cache and the arbiter data port:
// absorbs evictions in one cycle, drains them in the background, serves read hits.
module dcache_writeback_buffer
    import wbuf_types::*;
#(
    parameter int DEPTH  = 4,
    parameter int LINE_W = WBUF_LINE_W,
    parameter int ADDR_W = WBUF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] cpmem_address,
    input  logic [LINE_W-1:0] cpmem_wdata,
    input  logic              cpmem_write,
    input  logic              cpmem_read,
    output logic [LINE_W-1:0] cpmem_rdata,
    output logic              cpmem_resp,
    output logic [ADDR_W-1:0] dpmem_address,
    output logic [LINE_W-1:0] dpmem_wdata,
    output logic              dpmem_write,
    output logic              dpmem_read,
    input  logic [LINE_W-1:0] dpmem_rdata,
    input  logic              dpmem_resp,
    output logic              wbuf_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TAG_W = ADDR_W - LINE_OFFSET_W;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [DEPTH-1:0]             entry_valid;
    logic [DEPTH-1:0][TAG_W-1:0]  entry_tag;
    logic [DEPTH-1:0][LINE_W-1:0] entry_line;
    logic [PTR_W-1:0]             head;
    logic [PTR_W-1:0]             tail;
    logic [CNT_W-1:0]             count;

    ustate_t u_state, u_next;
    dstate_t d_state, d_next;
    logic    read_pending;
    logic [LINE_W-1:0] rdata_q;

    logic push, pop, coalesce, rd_hit_load, set_pending, rd_done;
    logic              m_hit;
    logic [PTR_W-1:0]  m_index;
    logic [LINE_W-1:0] m_line;
    logic [TAG_W-1:0]  req_tag;

    assign req_tag = cpmem_address[ADDR_W-1:LINE_OFFSET_W];

    // The head under an active drain is frozen: a write to its address becomes a new entry.
    wbuf_match #(
        .DEPTH  (DEPTH),
        .TAG_W  (TAG_W),
        .LINE_W (LINE_W)
    ) u_match (
        .valid        (entry_valid),
        .tags         (entry_tag),
        .lines        (entry_line),
        .head         (head),
        .lookup_tag   (req_tag),
        .exclude_head (cpmem_write && (d_state == D_WRITE)),
        .hit          (m_hit),
        .index        (m_index),
        .line         (m_line)
    );

    // Upstream: accepts cache writes/reads and produces the one-cycle response.
    always_comb begin
        u_next      = u_state;
        push        = 1'b0;
        coalesce    = 1'b0;
        rd_hit_load = 1'b0;
        set_pending = 1'b0;
        case (u_state)
            U_IDLE: begin
                if (rd_done) begin
                    u_next = U_RESP;
                end else if (!read_pending) begin
                    if (cpmem_write) begin
                        if (m_hit) begin
                            coalesce = 1'b1;
                            u_next   = U_RESP;
                        end else if (count != FULL) begin
                            push   = 1'b1;
                            u_next = U_RESP;
                        end
                    end else if (cpmem_read) begin
                        if (m_hit) begin
                            rd_hit_load = 1'b1;
                            u_next      = U_RESP;
                        end else begin
                            set_pending = 1'b1;
                        end
                    end
                end
            end
            U_RESP:  u_next = U_IDLE;
            default: u_next = U_IDLE;
        endcase
    end

    // Downstream: memory reads take priority over starting a drain; neither is aborted.
    always_comb begin
        d_next  = d_state;
        pop     = 1'b0;
        rd_done = 1'b0;
        case (d_state)
            D_IDLE: begin
                if (read_pending)      d_next = D_READ;
                else if (count != '0)  d_next = D_WRITE;
            end
            D_READ: begin
                if (dpmem_resp) begin
                    rd_done = 1'b1;
                    d_next  = D_IDLE;
                end
            end
            D_WRITE: begin
                if (dpmem_resp) begin
                    pop    = 1'b1;
                    d_next = D_IDLE;
                end
            end
            default: d_next = D_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            u_state      <= U_IDLE;
            d_state      <= D_IDLE;
            read_pending <= 1'b0;
            rdata_q      <= '0;
        end else begin
            u_state <= u_next;
            d_state <= d_next;
            if (set_pending)  read_pending <= 1'b1;
            else if (rd_done) read_pending <= 1'b0;
            if (rd_hit_load)  rdata_q <= m_line;
            else if (rd_done) rdata_q <= dpmem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            entry_valid <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
        end else begin
            if (pop) begin
                entry_valid[head] <= 1'b0;
                head              <= head + 1'b1;
            end
            if (push) begin
                entry_valid[tail] <= 1'b1;
                tail              <= tail + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: tag/line storage has no reset; the valid bits alone say whether a slot
    // holds anything, so stale contents after reset are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_tag[tail]  <= req_tag;
            entry_line[tail] <= cpmem_wdata;
        end else if (coalesce) begin
            entry_line[m_index] <= cpmem_wdata;
        end
    end

    always_comb begin
        dpmem_read    = (d_state == D_READ);
        dpmem_write   = (d_state == D_WRITE);
        dpmem_address = '0;
        dpmem_wdata   = '0;
        if (d_state == D_READ) begin
            dpmem_address = cpmem_address;
        end else if (d_state == D_WRITE) begin
            dpmem_address = {entry_tag[head], {LINE_OFFSET_W{1'b0}}};
            dpmem_wdata   = entry_line[head];
        end
    end

    assign cpmem_resp  = (u_state == U_RESP);
    assign cpmem_rdata = rdata_q;
    assign wbuf_empty  = (count == '0) && (d_state == D_IDLE);

    // The cache never issues a read and a write in the same cycle.
    assert property (@(posedge clk) disable iff (!reset_n) !(cpmem_read && cpmem_write));

endmodule

// File: tb/tb_dcache_writeback_buffer.sv
// Directed bench for dcache_writeback_buffer: a vector table for hit/coalesce traffic
// plus hand sequences for full-stall, read-miss ordering and mid-drain reset.
module tb_dcache_writeback_buffer;
    import wbuf_types::*;

    logic         clk;
    logic         reset_n;
    logic [31:0]  cpmem_address;
    logic [255:0] cpmem_wdata;
    logic         cpmem_write;
    logic         cpmem_read;
    logic [255:0] cpmem_rdata;
    logic         cpmem_resp;
    logic [31:0]  dpmem_address;
    logic [255:0] dpmem_wdata;
    logic         dpmem_write;
    logic         dpmem_read;
    logic [255:0] dpmem_rdata;
    logic         dpmem_resp;
    logic         wbuf_empty;

    dcache_writeback_buffer #(.DEPTH(4), .LINE_W(256), .ADDR_W(32)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cpmem_address (cpmem_address),
        .cpmem_wdata   (cpmem_wdata),
        .cpmem_write   (cpmem_write),
        .cpmem_read    (cpmem_read),
        .cpmem_rdata   (cpmem_rdata),
        .cpmem_resp    (cpmem_resp),
        .dpmem_address (dpmem_address),
        .dpmem_wdata   (dpmem_wdata),
        .dpmem_write   (dpmem_write),
        .dpmem_read    (dpmem_read),
        .dpmem_rdata   (dpmem_rdata),
        .dpmem_resp    (dpmem_resp),
        .wbuf_empty    (wbuf_empty)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mem_go   = 0;

    typedef struct {
        bit           rd;
        logic [31:0]  addr;
        logic [255:0] data;
        int           cyc;
    } mem_ev_t;

    mem_ev_t     log_q[$];
    wbuf_entry_t exp_q[$];

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;
        logic [255:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] pat(input logic [31:0] s);
        logic [255:0] p;
        for (int i = 0; i < 8; i++)
            p[i*32 +: 32] = (s + 32'(i * 7)) ^ 32'h5A5A_0000 ^ {s[15:0], s[31:16]};
        return p;
    endfunction

    function automatic logic [255:0] mem_data(input logic [31:0] a);
        return pat(a ^ 32'h00FF_FF00);
    endfunction

    function automatic wbuf_entry_t ent(input logic [31:0] a, input logic [255:0] l);
        wbuf_entry_t e;
        e.valid = 1'b1;
        e.tag   = a[31:5];
        e.line  = l;
        return e;
    endfunction

    // Arbiter model: answers after two enabled cycles, logs every completed transfer.
    logic         busy;
    int           wait_cnt;
    logic [31:0]  first_addr;
    logic [255:0] first_wdata;
    initial begin
        dpmem_resp  = 1'b0;
        dpmem_rdata = '0;
        busy        = 1'b0;
        wait_cnt    = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!reset_n) begin
                dpmem_resp = 1'b0;
                busy       = 1'b0;
                wait_cnt   = 0;
            end else if (dpmem_resp) begin
                dpmem_resp = 1'b0;
                busy       = 1'b0;
                wait_cnt   = 0;
            end else if (dpmem_write || dpmem_read) begin
                if (!busy) begin
                    busy        = 1'b1;
                    first_addr  = dpmem_address;
                    first_wdata = dpmem_wdata;
                end
                if (mem_go) begin
                    wait_cnt++;
                    if (wait_cnt >= 2) begin
                        check("dp_addr_stable", dpmem_address, first_addr);
                        check("dp_wdata_stable", dpmem_wdata, first_wdata);
                        if (dpmem_read) dpmem_rdata = mem_data(dpmem_address);
                        dpmem_resp = 1'b1;
                        log_q.push_back('{dpmem_read, dpmem_address, dpmem_wdata, cyc});
                    end
                end
            end
        end
    end

    task automatic wait_resp(output int lat, output int rc);
        lat = 0;
        rc  = -1000;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (cpmem_resp) begin
                lat = i;
                rc  = cyc;
                break;
            end
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [255:0] d, output int lat);
        int rc;
        @(negedge clk);
        cpmem_address = a;
        cpmem_wdata   = d;
        cpmem_write   = 1'b1;
        wait_resp(lat, rc);
        cpmem_write = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output int lat, output logic [255:0] rd);
        int rc;
        @(negedge clk);
        cpmem_address = a;
        cpmem_read    = 1'b1;
        wait_resp(lat, rc);
        rd = cpmem_rdata;
        cpmem_read = 1'b0;
    endtask

    task automatic wait_log(input int n);
        for (int i = 0; i < 200; i++) begin
            if (log_q.size() >= n) break;
            @(negedge clk);
        end
        check("log_reached", 256'(log_q.size()), 256'(n));
    endtask

    task automatic check_drain();
        check("drain_count", 256'(log_q.size()), 256'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            check("drain_kind", 256'(log_q[i].rd), 256'(0));
            check("drain_addr", log_q[i].addr, {exp_q[i].tag, 5'b0});
            check("drain_data", log_q[i].data, exp_q[i].line);
        end
    endtask

    task automatic settle();
        mem_go = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (wbuf_empty) break;
            @(negedge clk);
        end
        check("settle_empty", 256'(wbuf_empty), 256'(1));
        repeat (2) @(negedge clk);
        log_q.delete();
        exp_q.delete();
        mem_go = 1'b0;
    endtask

    initial begin
        int           lat;
        int           rc;
        bit           saw;
        logic [255:0] rd;

        vecs[0] = '{1'b1, 32'h0000_2000, pat(32'hB), '0};
        vecs[1] = '{1'b0, 32'h0000_2000, '0, pat(32'hB)};
        vecs[2] = '{1'b1, 32'h0000_2020, pat(32'hE), '0};
        vecs[3] = '{1'b0, 32'h0000_2020, '0, pat(32'hE)};
        vecs[4] = '{1'b0, 32'h0000_2000, '0, pat(32'hB)};
        vecs[5] = '{1'b1, 32'h0000_2020, pat(32'hF), '0};
        vecs[6] = '{1'b0, 32'h0000_2020, '0, pat(32'hF)};

        reset_n       = 1'b0;
        cpmem_address = '0;
        cpmem_wdata   = '0;
        cpmem_write   = 1'b0;
        cpmem_read    = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_empty", 256'(wbuf_empty), 256'(1));
        check("rst_cp_resp", 256'(cpmem_resp), 256'(0));
        check("rst_dp_write", 256'(dpmem_write), 256'(0));
        check("rst_dp_read", 256'(dpmem_read), 256'(0));
        check("rst_dp_addr", dpmem_address, '0);
        check("rst_cp_rdata", cpmem_rdata, '0);
        reset_n = 1'b1;

        // Single write, drain held off then released
        do_write(32'h0000_1000, pat(32'hA), lat);
        check("w1_latency", 256'(lat), 256'(1));
        repeat (3) @(negedge clk);
        check("w1_dp_write", 256'(dpmem_write), 256'(1));
        check("w1_dp_addr", dpmem_address, 32'h0000_1000);
        check("w1_dp_wdata", dpmem_wdata, pat(32'hA));
        check("w1_not_empty", 256'(wbuf_empty), 256'(0));
        mem_go = 1'b1;
        wait_log(1);
        @(negedge clk);
        check("w1_empty_after_pop", 256'(wbuf_empty), 256'(1));
        exp_q.push_back(ent(32'h0000_1000, pat(32'hA)));
        check_drain();
        settle();

        // Vector table: hits, hit on entry under drain, coalesce, all with drain stalled
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, lat);
                check("vec_wr_latency", 256'(lat), 256'(1));
            end else begin
                do_read(vecs[i].addr, lat, rd);
                check("vec_rd_latency", 256'(lat), 256'(1));
                check("vec_rd_data", rd, vecs[i].exp_rdata);
            end
        end
        check("vec_no_dp_read", 256'(dpmem_read), 256'(0));
        mem_go = 1'b1;
        exp_q.push_back(ent(32'h0000_2000, pat(32'hB)));
        exp_q.push_back(ent(32'h0000_2020, pat(32'hF)));
        wait_log(2);
        repeat (6) @(negedge clk);
        check_drain();
        settle();

        // Full buffer: fifth write stalls until the cycle after the first pop
        for (int i = 1; i <= 4; i++) begin
            do_write(32'(i) << 8, pat(32'(i) << 8), lat);
            check("full_fill_latency", 256'(lat), 256'(1));
        end
        @(negedge clk);
        cpmem_address = 32'h0000_0500;
        cpmem_wdata   = pat(32'h500);
        cpmem_write   = 1'b1;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (cpmem_resp) saw = 1'b1;
        end
        check("full_stalled", 256'(saw), 256'(0));
        mem_go = 1'b1;
        wait_resp(lat, rc);
        cpmem_write = 1'b0;
        check("full_accepted", 256'(lat != 0), 256'(1));
        if (log_q.size() > 0) check("full_accept_after_pop", 256'(rc - log_q[0].cyc), 256'(2));
        else                  check("full_pop_seen", 256'(log_q.size()), 256'(1));
        for (int i = 1; i <= 5; i++) exp_q.push_back(ent(32'(i) << 8, pat(32'(i) << 8)));
        wait_log(5);
        check_drain();
        settle();

        // Coalesce away from head; write to the head under drain makes a new entry
        do_write(32'h0000_5000, pat(32'h50), lat);
        check("co_w0_latency", 256'(lat), 256'(1));
        do_write(32'h0000_6000, pat(32'hC), lat);
        check("co_w1_latency", 256'(lat), 256'(1));
        do_write(32'h0000_6000, pat(32'hD), lat);
        check("co_w2_latency", 256'(lat), 256'(1));
        do_write(32'h0000_5000, pat(32'h51), lat);
        check("co_w3_latency", 256'(lat), 256'(1));
        do_read(32'h0000_5000, lat, rd);
        check("co_rd_youngest", rd, pat(32'h51));
        do_read(32'h0000_6000, lat, rd);
        check("co_rd_coalesced", rd, pat(32'hD));
        mem_go = 1'b1;
        exp_q.push_back(ent(32'h0000_5000, pat(32'h50)));
        exp_q.push_back(ent(32'h0000_6000, pat(32'hD)));
        exp_q.push_back(ent(32'h0000_5000, pat(32'h51)));
        wait_log(3);
        repeat (8) @(negedge clk);
        check_drain();
        settle();

        // Read miss waits for the in-flight drain, then goes to memory
        do_write(32'h0000_3000, pat(32'h30), lat);
        check("rm_w_latency", 256'(lat), 256'(1));
        @(negedge clk);
        cpmem_address = 32'h0000_4000;
        cpmem_read    = 1'b1;
        repeat (4) @(negedge clk);
        check("rm_no_read_yet", 256'(dpmem_read), 256'(0));
        check("rm_drain_active", 256'(dpmem_write), 256'(1));
        check("rm_no_resp_yet", 256'(cpmem_resp), 256'(0));
        mem_go = 1'b1;
        wait_resp(lat, rc);
        rd = cpmem_rdata;
        cpmem_read = 1'b0;
        check("rm_rdata", rd, mem_data(32'h0000_4000));
        check("rm_events", 256'(log_q.size()), 256'(2));
        if (log_q.size() >= 2) begin
            check("rm_first_is_write", 256'(log_q[0].rd), 256'(0));
            check("rm_first_addr", log_q[0].addr, 32'h0000_3000);
            check("rm_second_is_read", 256'(log_q[1].rd), 256'(1));
            check("rm_second_addr", log_q[1].addr, 32'h0000_4000);
            check("rm_resp_delay", 256'(rc - log_q[1].cyc), 256'(1));
        end
        settle();

        // Reset in the middle of a drain
        do_write(32'h0000_7000, pat(32'h70), lat);
        check("rst_w_latency", 256'(lat), 256'(1));
        repeat (2) @(negedge clk);
        check("rst_pre_drain", 256'(dpmem_write), 256'(1));
        #1 reset_n = 1'b0;
        #1;
        check("rst_mid_dp_write", 256'(dpmem_write), 256'(0));
        check("rst_mid_dp_read", 256'(dpmem_read), 256'(0));
        check("rst_mid_dp_addr", dpmem_address, '0);
        check("rst_mid_dp_wdata", dpmem_wdata, '0);
        check("rst_mid_cp_resp", 256'(cpmem_resp), 256'(0));
        check("rst_mid_empty", 256'(wbuf_empty), 256'(1));
        @(negedge clk);
        reset_n = 1'b1;
        log_q.delete();
        mem_go = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_no_drain_log", 256'(log_q.size()), 256'(0));
        check("rst_no_drain_write", 256'(dpmem_write), 256'(0));
        check("rst_post_empty", 256'(wbuf_empty), 256'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
